// File: rtl/blink_code_gen.sv
// Status-code LED blinker: N blinks, then a gap; code 0 turns the LED off.
// Define BLINK_CODE_REPEAT_EN to loop the pattern until the next load.
module blink_code_gen #(
  parameter int TICK_DIV  = 25000,
  parameter int ON_TICKS  = 4,
  parameter int OFF_TICKS = 4,
  parameter int GAP_TICKS = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] code_in,
  input  logic       code_valid,
  output logic       busy,
  output logic       led
);

  localparam logic [19:0] TICK_MAX = 20'(TICK_DIV - 1);
  localparam logic [7:0]  ON_LAST  = 8'(ON_TICKS - 1);
  localparam logic [7:0]  OFF_LAST = 8'(OFF_TICKS - 1);
  localparam logic [7:0]  GAP_LAST = 8'(GAP_TICKS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ON,
    S_OFF,
    S_GAP
  } state_e;

  state_e      state_q;
  logic [19:0] tick_q, tick_d;
  logic [7:0]  st_q;
  logic [2:0]  blink_q;
  logic [2:0]  code_q;
  logic        led_q;
  logic        busy_q;
  logic        tick;

  assign tick = (tick_q == TICK_MAX);
  assign led  = led_q;
  assign busy = busy_q;

  always_comb begin
    tick_d = tick_q + 20'd1;
    if (code_valid || tick) begin
      tick_d = '0;
    end
  end

  // A load wins over any tick-driven move in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      tick_q  <= '0;
      st_q    <= '0;
      blink_q <= '0;
      code_q  <= '0;
      led_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      tick_q <= tick_d;
      if (code_valid) begin
        code_q  <= code_in;
        st_q    <= '0;
        blink_q <= '0;
        if (code_in != 3'd0) begin
          state_q <= S_ON;
          led_q   <= 1'b1;
          busy_q  <= 1'b1;
        end else begin
          state_q <= S_IDLE;
          led_q   <= 1'b0;
          busy_q  <= 1'b0;
        end
      end else if (tick) begin
        unique case (state_q)
          S_IDLE: begin
            st_q <= '0;
          end
          S_ON: begin
            if (st_q == ON_LAST) begin
              st_q  <= '0;
              led_q <= 1'b0;
              if (blink_q == code_q - 3'd1) begin
                state_q <= S_GAP;
              end else begin
                blink_q <= blink_q + 3'd1;
                state_q <= S_OFF;
              end
            end else begin
              st_q <= st_q + 8'd1;
            end
          end
          S_OFF: begin
            if (st_q == OFF_LAST) begin
              st_q    <= '0;
              state_q <= S_ON;
              led_q   <= 1'b1;
            end else begin
              st_q <= st_q + 8'd1;
            end
          end
          S_GAP: begin
            if (st_q == GAP_LAST) begin
              st_q <= '0;
`ifdef BLINK_CODE_REPEAT_EN
              blink_q <= '0;
              state_q <= S_ON;
              led_q   <= 1'b1;
`else
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
`endif
            end else begin
              st_q <= st_q + 8'd1;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_blink_code_gen.sv
// Bench for blink_code_gen: cycle model from pattern arithmetic plus
// directed loads, mid-pattern reloads and an asynchronous reset.
module tb_blink_code_gen;

  localparam int TD  = 4;
  localparam int ONT = 2;
  localparam int OFT = 2;
  localparam int GPT = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] code_in = 3'd0;
  logic       code_valid = 1'b0;
  logic       busy, led;

  int errors = 0;
  int checks = 0;

  blink_code_gen #(
    .TICK_DIV (TD),
    .ON_TICKS (ONT),
    .OFF_TICKS(OFT),
    .GAP_TICKS(GPT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .code_in   (code_in),
    .code_valid(code_valid),
    .busy      (busy),
    .led       (led)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b want %b at %0t", name, got, exp, $time);
    end
  endtask

  // Model: code loaded and cycles elapsed since the load edge.
  int m_code = 0;
  int m_t = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_code = 0;
      m_t = 0;
    end else if (code_valid) begin
      m_code = int'(code_in);
      m_t = 0;
    end else if (m_t < 1000000) begin
      m_t++;
    end
  end

  function automatic void model(output logic e_led, output logic e_busy);
    int on_c, off_c, gap_c, len, tt;
    on_c  = ONT * TD;
    off_c = OFT * TD;
    gap_c = GPT * TD;
    e_led  = 1'b0;
    e_busy = 1'b0;
    if (m_code != 0) begin
      len = m_code * on_c + (m_code - 1) * off_c + gap_c;
`ifdef BLINK_CODE_REPEAT_EN
      tt = m_t % len;
`else
      tt = m_t;
`endif
      if (tt < len) begin
        e_busy = 1'b1;
        e_led  = (tt < len - gap_c) && ((tt % (on_c + off_c)) < on_c);
      end
    end
  endfunction

  always @(negedge clk) begin
    logic el, eb;
    model(el, eb);
    chk("model_led", led, el);
    chk("model_busy", busy, eb);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [2:0] c);
    code_in = c;
    code_valid = 1'b1;
    step();
    code_valid = 1'b0;
  endtask

  logic rl [0:79];
  logic rb [0:79];

  initial begin
    #2;
    chk("reset_led", led, 1'b0);
    chk("reset_busy", busy, 1'b0);
    repeat (3) step();
    rst_n = 1'b1;
    repeat (5) step();
    chk("idle_busy", busy, 1'b0);

    // Code 3 played once (repeat runs loop instead, checked by model).
    load(3'd3);
    for (int k = 0; k < 60; k++) begin
      rl[k] = led;
      rb[k] = busy;
      step();
    end
    chk("c3_t0_led", rl[0], 1'b1);
    chk("c3_t7_led", rl[7], 1'b1);
    chk("c3_t8_led", rl[8], 1'b0);
    chk("c3_t15_led", rl[15], 1'b0);
    chk("c3_t16_led", rl[16], 1'b1);
    chk("c3_t39_led", rl[39], 1'b1);
    chk("c3_t40_led", rl[40], 1'b0);
    chk("c3_t55_busy", rb[55], 1'b1);
`ifndef BLINK_CODE_REPEAT_EN
    chk("c3_t56_busy", rb[56], 1'b0);
    chk("c3_t56_led", rl[56], 1'b0);
`endif

`ifdef BLINK_CODE_REPEAT_EN
    load(3'd1);
    for (int k = 0; k < 80; k++) begin
      rl[k] = led;
      rb[k] = busy;
      step();
    end
    chk("r1_t7_led", rl[7], 1'b1);
    chk("r1_t8_led", rl[8], 1'b0);
    chk("r1_t23_led", rl[23], 1'b0);
    chk("r1_t24_led", rl[24], 1'b1);
    chk("r1_t48_led", rl[48], 1'b1);
    chk("r1_t72_led", rl[72], 1'b1);
    chk("r1_t79_busy", rb[79], 1'b1);
`endif

    // Code 0 during a code 5 pattern.
    load(3'd5);
    repeat (20) step();
    load(3'd0);
    chk("c0_led", led, 1'b0);
    chk("c0_busy", busy, 1'b0);
    repeat (10) step();

    // Reload on the ON-ending tick: load during t=7 of code 3.
    load(3'd3);
    repeat (7) step();
    load(3'd2);
    for (int k = 0; k < 10; k++) begin
      rl[k] = led;
      step();
    end
    chk("ld_t0_led", rl[0], 1'b1);
    chk("ld_t7_led", rl[7], 1'b1);
    chk("ld_t8_led", rl[8], 1'b0);
    repeat (30) step();

    // Multi-cycle strobe: pattern starts after the last strobe cycle.
    code_in = 3'd2;
    code_valid = 1'b1;
    repeat (3) step();
    code_valid = 1'b0;
    repeat (12) step();

    // Asynchronous reset mid-OFF.
    load(3'd3);
    repeat (10) step();
    chk("pre_rst_led", led, 1'b0);
    chk("pre_rst_busy", busy, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_led", led, 1'b0);
    chk("rst_busy", busy, 1'b0);
    step();
    rst_n = 1'b1;
    repeat (40) step();
    chk("post_rst_busy", busy, 1'b0);
    load(3'd1);
    chk("post_rst_led", led, 1'b1);
    repeat (30) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/blink_code_gen.md
BLINK_CODE_GEN -- requirements
Module: blink_code_gen

Interface
REQ-001 The block SHALL have parameter TICK_DIV, default 25000: clk cycles per timing tick, legal range 2..1048575.
REQ-002 The block SHALL have parameter ON_TICKS, default 4: ticks the led is high per blink, legal range 1..255.
REQ-003 The block SHALL have parameter OFF_TICKS, default 4: ticks the led is low between blinks, legal range 1..255.
REQ-004 The block SHALL have parameter GAP_TICKS, default 16: ticks the led is low after the last blink, legal range 1..255.
REQ-005 The block SHALL have port clk, input, 1 bit: single system clock (100 MHz).
REQ-006 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-007 The block SHALL have port code_in, input, 3 bits: status code, giving the number of blinks (0 = off).
REQ-008 The block SHALL have port code_valid, input, 1 bit: single-cycle strobe that loads code_in.
REQ-009 The block SHALL have port busy, output, 1 bit: high while a pattern is playing.
REQ-010 The block SHALL have port led, output, 1 bit: registered drive to the status LED.

Function
REQ-011 The block SHALL have a free tick counter that runs 0..TICK_DIV-1, wraps to 0, and asserts an internal tick when the count equals TICK_DIV-1.
REQ-012 The block SHALL implement FSM states IDLE, ON, OFF and GAP.
REQ-013 The FSM SHALL set led=1 only in ON, and busy=1 in ON, OFF and GAP.
REQ-014 When code_valid=1 in any state, the block SHALL latch code_in, clear the tick counter, the state-tick counter and the blink counter, and select the next state as follows:
  - ON if code_in!=0;
  - IDLE if code_in==0.
REQ-015 Latency SHALL be exactly one cycle: with code_valid high in cycle n, led and busy change in cycle n+1.
REQ-016 A code_valid load SHALL take priority over any tick-driven transition in the same cycle.
REQ-017 The state-tick counter SHALL advance only on tick, and SHALL reset to 0 on every state change.
REQ-018 On the tick at which ON has lasted ON_TICKS ticks, the FSM SHALL move to GAP if blink_cnt==code-1, otherwise it SHALL increment blink_cnt and move to OFF.
REQ-019 On the tick at which OFF has lasted OFF_TICKS ticks, the FSM SHALL move to ON.
REQ-020 On the tick at which GAP has lasted GAP_TICKS ticks, the FSM SHALL behave per REQ-026/REQ-027.
REQ-021 State durations SHALL be exact multiples of TICK_DIV cycles: ON lasts ON_TICKS*TICK_DIV cycles, with no off-by-one.
REQ-022 Counters SHALL be sized for the parameter maxima and SHALL never wrap inside a state.
REQ-023 code_valid held high for several cycles SHALL reload each cycle, so that the pattern starts after the last strobe cycle.

Reset
REQ-024 While rst_n=0, the block SHALL immediately force state=IDLE, led=0, busy=0, the latched code to 0, and all counters to 0.
REQ-025 Reset asserted mid-pattern SHALL abort the pattern; after release the block SHALL stay in IDLE until the next code_valid.

Configuration
REQ-026 With macro BLINK_CODE_REPEAT_EN defined, the end of GAP SHALL return to ON with blink_cnt=0, repeating the pattern indefinitely until a new load or a reset.
REQ-027 With BLINK_CODE_REPEAT_EN undefined, the end of GAP SHALL go to IDLE, drop busy, and play the pattern once per load.

Verification (bench parameters TICK_DIV=4, ON_TICKS=2, OFF_TICKS=2, GAP_TICKS=4)
REQ-028 The bench SHALL load code 3 without REPEAT_EN and check the following response:
  - led high for 8 cycles, low for 8, high for 8, low for 8, high for 8;
  - led then low, with busy falling 56 cycles after the load.
REQ-029 The bench SHALL load code 1 with REPEAT_EN and check that led shows an 8-cycle-high / 16-cycle-low period repeating for at least 3 periods, with busy constantly high.
REQ-030 The bench SHALL load code 0 during a code 5 pattern and check that led=0 and busy=0 from the next cycle.
REQ-031 The bench SHALL load code 2 in the same cycle as an ON-end tick and check that the new pattern starts: led stays high for a full 8 cycles from the load.
REQ-032 The bench SHALL assert rst_n low mid-OFF and check that led=0 and busy=0 with no clock edge, and that the block stays in IDLE after release until a code_valid.
